mult_share_arbiter_taint: RTL and testbench



---
 rtl/mult_share_arbiter_taint.sv | 232 +++++++++++++++++++++++
 tb/tb_mult_share_arbiter_taint.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter_taint.sv
// mult_share_arbiter_taint
//
// Shares one taint-tracked sequential multiplier among NUM_REQ requesters.
// A winner is picked among the active req bits and its operands are latched.
// The multiplier gets a one-cycle start pulse, and the block then waits for
// mul_done. The captured 2*WIDTH product is returned to the winner with a
// one-cycle done pulse. Every control/data output carries a 1-bit taint
// derived from the inputs that influenced it.
//
// Configuration macro:
//   MULT_ARB_RR_EN  defined   -> round-robin arbitration, with a pointer that
//                                holds the last winner + 1 and a sticky rr_t
//                                taint
//                   undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req / req_t              per-requester request level and its taint
//   mcand / mcand_t          packed multiplicands (slice i = requester i) + taints
//   mplier / mplier_t        packed multipliers + taints
//   gnt / gnt_t              one-hot grant, held from grant until RESP exit
//   done / done_t            one-cycle completion pulse to the winner
//   product / product_t      last captured product, held until the next capture
//   busy                     high in every state except IDLE
//   mul_start / mul_start_t  multiplier start pulse (ISSUE only)
//   mul_mcand / mul_mplier   latched operands; mul_op_t is their taint
//   mul_done / mul_done_t    product-done from the multiplier (WAIT only)
//   mul_product / _t         multiplier result and its taint
//
// Handshake: the requester contract is level-based, not valid/ready.
// - A requester raises req and keeps its operands stable until gnt shows it
//   was chosen.
// - After gnt, req and operands are don't-care. The operation always
//   completes with a single done[w] pulse.
// - A req dropped before it is granted is simply never served.
module mult_share_arbiter_taint #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_t,
    input  logic [NUM_REQ*WIDTH-1:0]   mcand,
    input  logic [NUM_REQ-1:0]         mcand_t,
    input  logic [NUM_REQ*WIDTH-1:0]   mplier,
    input  logic [NUM_REQ-1:0]         mplier_t,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gnt_t,
    output logic [NUM_REQ-1:0]         done,
    output logic                       done_t,
    output logic [2*WIDTH-1:0]         product,
    output logic                       product_t,
    output logic                       busy,
    output logic                       mul_start,
    output logic                       mul_start_t,
    output logic [WIDTH-1:0]           mul_mcand,
    output logic [WIDTH-1:0]           mul_mplier,
    output logic                       mul_op_t,
    input  logic                       mul_done,
    input  logic                       mul_done_t,
    input  logic [2*WIDTH-1:0]         mul_product,
    input  logic                       mul_product_t
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Set when mul_done_t was high in any WAIT cycle: the length of WAIT,
    // and therefore when the product is captured, depends on mul_done.
    logic wait_t;
    logic wait_t_next;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             gnt_t_next;

`ifdef MULT_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    logic             rr_t;
`endif

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef MULT_ARB_RR_EN
    // Scan from the pointer upward, wrapping around. The loop runs backwards
    // so that the candidate closest to the pointer is the last one assigned.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    // The choice of winner also depends on the pointer history.
    assign gnt_t_next = (|req_t) | rr_t;
`else
    // Fixed priority: the backwards scan leaves the lowest active index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end

    assign gnt_t_next = |req_t;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        wait_t_next = wait_t;
        busy        = 1'b1;
        mul_start   = 1'b0;
        mul_start_t = 1'b0;
        done        = '0;
        done_t      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (win_found) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_start   = 1'b1;
                mul_start_t = gnt_t;
                wait_t_next = 1'b0;
                state_next  = S_WAIT;
            end
            S_WAIT: begin
                // The done-cycle's taint counts too: it decided the capture.
                wait_t_next = wait_t | mul_done_t;
                if (mul_done) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                done       = gnt;
                done_t     = gnt_t | wait_t;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and taint registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt        <= '0;
            gnt_t      <= 1'b0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_op_t   <= 1'b0;
            wait_t     <= 1'b0;
            product    <= '0;
            product_t  <= 1'b0;
`ifdef MULT_ARB_RR_EN
            rr_ptr     <= '0;
            rr_t       <= 1'b0;
`endif
        end else begin
            wait_t <= wait_t_next;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        gnt        <= NUM_REQ'(1) << win_idx;
                        gnt_t      <= gnt_t_next;
                        mul_mcand  <= mcand[int'(win_idx)*WIDTH +: WIDTH];
                        mul_mplier <= mplier[int'(win_idx)*WIDTH +: WIDTH];
                        mul_op_t   <= mcand_t[win_idx] | mplier_t[win_idx];
`ifdef MULT_ARB_RR_EN
                        rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                  : win_idx + 1'b1;
                        rr_t   <= rr_t | gnt_t_next;
`endif
                    end
                end
                S_WAIT: begin
                    if (mul_done) begin
                        product   <= mul_product;
                        product_t <= mul_product_t | mul_op_t | wait_t_next;
                    end
                end
                S_RESP: begin
                    gnt      <= '0;
                    gnt_t    <= 1'b0;
                    mul_op_t <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter_taint.sv
module tb_mult_share_arbiter_taint;

  localparam int W = 8;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req, req_t, mcand_t, mplier_t;
  logic [N*W-1:0] mcand, mplier;
  logic [N-1:0]   gnt, done;
  logic           gnt_t, done_t, product_t, busy, mul_start, mul_start_t, mul_op_t;
  logic [2*W-1:0] product, mul_product;
  logic [W-1:0]   mul_mcand, mul_mplier;
  logic           mul_done, mul_done_t, mul_product_t;

  mult_share_arbiter_taint #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_t(req_t),
    .mcand(mcand), .mcand_t(mcand_t),
    .mplier(mplier), .mplier_t(mplier_t),
    .gnt(gnt), .gnt_t(gnt_t),
    .done(done), .done_t(done_t),
    .product(product), .product_t(product_t),
    .busy(busy),
    .mul_start(mul_start), .mul_start_t(mul_start_t),
    .mul_mcand(mul_mcand), .mul_mplier(mul_mplier), .mul_op_t(mul_op_t),
    .mul_done(mul_done), .mul_done_t(mul_done_t),
    .mul_product(mul_product), .mul_product_t(mul_product_t)
  );

  // ---------------- reference model state ----------------
  logic [W-1:0]   mc[N];
  logic [W-1:0]   mp[N];
  bit             mct[N];
  bit             mpt[N];
  int             rr_ptr_m = 0;
  bit             rr_t_m = 0;
  logic [2*W-1:0] prod_m = '0;
  bit             prod_t_m = 0;
  logic [2*W-1:0] exp_q[$];
  int             served_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_operands();
    for (int i = 0; i < N; i++) begin
      mcand[i*W +: W]  = mc[i];
      mplier[i*W +: W] = mp[i];
      mcand_t[i]       = mct[i];
      mplier_t[i]      = mpt[i];
    end
  endtask

  task automatic clear_operands();
    for (int i = 0; i < N; i++) begin
      mc[i] = '0; mp[i] = '0; mct[i] = 0; mpt[i] = 0;
    end
    drive_operands();
  endtask

  // Who should win: lowest index, or first active at/after the pointer.
  function automatic int pick(input logic [N-1:0] r);
`ifdef MULT_ARB_RR_EN
    for (int k = 0; k < N; k++)
      if (r[(rr_ptr_m + k) % N]) return (rr_ptr_m + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (r[i]) return i;
`endif
    return -1;
  endfunction

  function automatic bit ctl_taint(input logic [N-1:0] rt);
`ifdef MULT_ARB_RR_EN
    return (|rt) | rr_t_m;
`else
    return |rt;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_gnt_t"}, gnt_t, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_done_t"}, done_t, 0);
    chk({tag, "_product"}, product, 0);
    chk({tag, "_product_t"}, product_t, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mul_start"}, {mul_start, mul_start_t}, 0);
    chk({tag, "_mul_ops"}, {mul_mcand, mul_mplier}, 0);
    chk({tag, "_mul_op_t"}, mul_op_t, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0; req_t = '0;
    mul_done = 1'b0; mul_done_t = 1'b0; mul_product = '0; mul_product_t = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rr_ptr_m = 0; rr_t_m = 0; prod_m = '0; prod_t_m = 0;
  endtask

  // Play one transaction, acting as requesters and as the multiplier.
  // Called and returns at a falling edge with the DUT idle.
  // md_mode: 0 = multiplier taints low, 1 = high, 2 = random per cycle.
  task automatic run_op(input logic [N-1:0] r, input logic [N-1:0] rt, input int lat,
                        input int md_mode, input bit hold, input bit abort);
    int w;
    bit gt, opt, wt, mdt, mprt;
    logic [2*W-1:0] p;
    logic [W-1:0] lm, lp;
    chk("pre_idle_busy", busy, 0);
    w = pick(r);
    req = r; req_t = rt;
    drive_operands();
    @(negedge clk);
    // ISSUE cycle
    gt  = ctl_taint(rt);
    opt = mct[w] | mpt[w];
    lm  = mc[w]; lp = mp[w];
    p   = {{W{1'b0}}, lm} * {{W{1'b0}}, lp};
    exp_q.push_back(p);
    chk("issue_gnt", gnt, 32'(1) << w);
    chk("issue_gnt_t", gnt_t, gt);
    chk("issue_busy", busy, 1);
    chk("issue_start", mul_start, 1);
    chk("issue_start_t", mul_start_t, gt);
    chk("issue_mcand", mul_mcand, lm);
    chk("issue_mplier", mul_mplier, lp);
    chk("issue_op_t", mul_op_t, opt);
    chk("issue_done", done, 0);
    chk("issue_prod_hold", {product_t, product}, {prod_t_m, prod_m});
    rr_ptr_m = (w + 1) % N;
    rr_t_m   = rr_t_m | gt;
    if (!hold) req = '0;
    // The winner may change its operands once granted.
    mc[w] = W'($urandom_range(0, 255));
    mp[w] = W'($urandom_range(0, 255));
    drive_operands();
    // A stray mul_done outside WAIT must be ignored.
    mul_done      = 1'($urandom_range(0, 1));
    mul_done_t    = 1'($urandom_range(0, 1));
    mul_product   = 16'($urandom_range(0, 65535));
    @(negedge clk);
    // first WAIT cycle
    chk("wait_start_low", {mul_start, mul_start_t}, 0);
    chk("wait_ops_held", {mul_mcand, mul_mplier}, {lm, lp});
    chk("wait_prod_hold", {product_t, product}, {prod_t_m, prod_m});
    mul_done = 1'b0; mul_done_t = 1'b0;
    if (abort) begin
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("rst_wait");
      rst = 1'b0; req = '0; req_t = '0;
      void'(exp_q.pop_back());
      rr_ptr_m = 0; rr_t_m = 0; prod_m = '0; prod_t_m = 0;
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
      return;
    end
    wt = 0;
    for (int i = 0; i < lat; i++) begin
      mdt = (md_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(md_mode);
      mul_done = 1'b0; mul_done_t = mdt; wt |= mdt;
      @(negedge clk);
      chk("wait_busy", busy, 1);
      chk("wait_gnt_onehot", $onehot(gnt), 1);
      chk("wait_done", done, 0);
    end
    mdt  = (md_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(md_mode);
    mprt = (md_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(md_mode);
    wt |= mdt;
    mul_done = 1'b1; mul_done_t = mdt; mul_product = p; mul_product_t = mprt;
    @(negedge clk);
    // RESP cycle
    prod_m   = exp_q.pop_front();
    prod_t_m = mprt | opt | wt;
    mul_done = 1'b0; mul_done_t = 1'b0; mul_product_t = 1'b0;
    mul_product = 16'($urandom_range(0, 65535));
    chk("resp_product", product, prod_m);
    chk("resp_product_t", product_t, prod_t_m);
    chk("resp_done", done, 32'(1) << w);
    chk("resp_done_t", done_t, gt | wt);
    chk("resp_gnt", gnt, 32'(1) << w);
    chk("resp_busy", busy, 1);
    @(negedge clk);
    // back in IDLE
    chk("idle_gnt", {gnt, gnt_t}, 0);
    chk("idle_op_t", mul_op_t, 0);
    chk("idle_done", {done, done_t}, 0);
    chk("idle_busy", busy, 0);
    chk("idle_product", {product_t, product}, {prod_t_m, prod_m});
    served_q.push_back(w);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int order_exp[4];
    rst = 1'b1;
    clear_operands();
    do_reset();
    check_all_zero("reset");

    // Single request 13*11
    mc[1] = 8'd13; mp[1] = 8'd11;
    run_op(4'b0010, 4'b0000, 2, 0, 0, 0);
    chk("single_product", product, 143);
    chk("single_product_t", product_t, 0);

    // Contention with req held continuously
    do_reset();
    clear_operands();
    for (int i = 0; i < N; i++) begin
      mc[i] = W'(i + 2); mp[i] = W'(i + 5);
    end
    served_q.delete();
    for (int i = 0; i < 4; i++) run_op(4'b1011, 4'b0000, 1, 0, 1, 0);
    req = '0;
`ifdef MULT_ARB_RR_EN
    order_exp = '{0, 1, 3, 0};
`else
    order_exp = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) chk("contention_order", served_q[i], order_exp[i]);

    // Operand taint only
    do_reset();
    clear_operands();
    mc[2] = 8'd7; mp[2] = 8'd9; mct[2] = 1;
    run_op(4'b0100, 4'b0000, 1, 0, 0, 0);
    chk("op_taint_product_t", product_t, 1);

    // Control taint: req_t[3] while requester 0 wins, mul_done_t in WAIT
    do_reset();
    clear_operands();
    mc[0] = 8'd3; mp[0] = 8'd4;
    run_op(4'b1001, 4'b1000, 2, 1, 0, 0);
    chk("ctl_taint_winner", served_q[$], 0);
    chk("ctl_taint_product_t", product_t, 1);

    // Reset mid-WAIT, then a fresh 255*255
    mc[1] = 8'd20; mp[1] = 8'd30;
    run_op(4'b0010, 4'b0000, 3, 0, 0, 1);
    clear_operands();
    mc[2] = 8'd255; mp[2] = 8'd255;
    run_op(4'b0100, 4'b0000, 2, 0, 0, 0);
    chk("after_rst_product", product, 65025);
    chk("after_rst_taint", {product_t, gnt_t}, 0);

    // req[0] dropped one cycle after grant still completes
    mc[0] = 8'd17; mp[0] = 8'd19;
    run_op(4'b0001, 4'b0000, 1, 0, 0, 0);
    chk("drop_after_winner", served_q[$], 0);

    // req[0] dropped before grant is never served
    req = 4'b0001;
    #2 req = '0;
    @(negedge clk);
    chk("drop_before_busy", busy, 0);
    chk("drop_before_gnt", gnt, 0);
    @(negedge clk);
    chk("drop_before_busy2", busy, 0);

    // Random transactions
    for (int n = 0; n < 25; n++) begin
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) begin
        mc[i]  = W'($urandom_range(0, 255));
        mp[i]  = W'($urandom_range(0, 255));
        mct[i] = 1'($urandom_range(0, 3) == 0);
        mpt[i] = 1'($urandom_range(0, 3) == 0);
      end
      r = N'($urandom_range(1, (1 << N) - 1));
      run_op(r, N'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : 0),
             $urandom_range(0, 4), 2, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
